dsec_mem_con: RTL and testbench
===============================

# dsec_mem_con

Burst memory controller between the DSEC test controller and the on-board synchronous SRAM. A one-cycle `go` with `w_rn` and a 13-bit start `address` launches a fixed-length burst. Write bursts store the DSEC output stream, qualified by `valid`, into SRAM. Read bursts stream SRAM contents back to the DSEC input with `rd_valid` aligned to the SRAM read latency, and `done` marks completion.

## Interface
- `ADDR_W`, 13: SRAM address width.
- `DATA_W`, 8: data word width.
- `BURST_LEN`, 16: words per burst; legal range 1..256.
- `RD_LAT`, 1: SRAM read latency in cycles, from `sram_ce`+address to `sram_rdata`; legal range 1..4.
- Reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `address`  in  ADDR_W  burst start address; sampled with `go`.
- `w_rn`  in  1  1 = write burst, 0 = read burst; sampled with `go`.
- `go`  in  1  burst request; honoured only in IDLE.
- `valid`  in  1  write-data qualifier; one word accepted per cycle it is high in WRITE.
- `wr_data`  in  DATA_W  write word from the DSEC output.
- `rd_data`  out  DATA_W  read word to the DSEC input; equals `sram_rdata`.
- `rd_valid`  out  1  `rd_data` holds a burst word this cycle.
- `busy`  out  1  high in WRITE, READ and DRAIN.
- `done`  out  1  one-cycle completion pulse.
- `sram_ce`  out  1  SRAM access enable.
- `sram_we`  out  1  SRAM write enable; only meaningful with `sram_ce`.
- `sram_addr`  out  ADDR_W  SRAM address.
- `sram_wdata`  out  DATA_W  SRAM write data.
- `sram_rdata`  in  DATA_W  SRAM read data.

## Operation
- States:
  - IDLE: `go`=1 latches `address` into the address register, clears the beat counter and moves to WRITE if `w_rn`=1, else READ. `go`=0 holds IDLE.
  - WRITE:
    - `sram_ce` = `sram_we` = `valid`; `sram_addr` = address register; `sram_wdata` = `wr_data`, all combinational.
    - On each cycle with `valid`=1, the address and beat count increment.
    - When `valid`=1 and count = BURST_LEN-1, go to DONE.
    - `valid`=0 stalls: no access, no increment.
  - READ:
    - `sram_ce`=1, `sram_we`=0 every cycle; address and count increment each cycle.
    - On the issue with count = BURST_LEN-1, go to DRAIN.
  - DRAIN: no access. Stay until the read-valid pipeline is empty, then go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Read-valid pipeline:
  - RD_LAT-stage shift register, shifted every cycle.
  - Stage 0 is loaded with the READ-state issue strobe.
  - `rd_valid` = last stage.
- Address arithmetic:
  - ADDR_W-bit modulo; 13'h1FFF + 1 wraps to 13'h0000.
  - A burst may cross the wrap.
- Beat counter: width clog2(BURST_LEN+1), unsigned.
- `go` outside IDLE is ignored, including in DONE; `address` and `w_rn` are don't-care there.
- `busy` = 0 in IDLE and DONE.
- Reset:
  - Reset (also mid-burst) forces IDLE and clears the address, counter and read pipeline.
  - All outputs are 0 in the cycle after reset: `busy`, `done`, `rd_valid`, `sram_ce`, `sram_we`, `sram_addr`=0, `sram_wdata`=0.
  - `rd_data` follows `sram_rdata`.
  - An in-flight read is dropped and its `rd_valid` never appears.

## Timing
- `go` sampled high at edge t: `busy`=1 from t.
  - Write: the first write can occur in cycle t.
  - Read: the first read is issued in cycle t.
- Read burst:
  - Issues in cycles t..t+BURST_LEN-1.
  - `rd_valid` is high in cycles t+RD_LAT .. t+RD_LAT+BURST_LEN-1, contiguous.
  - DRAIN lasts RD_LAT cycles; `done` pulses in cycle t+BURST_LEN+RD_LAT.
- Write burst with no stalls: writes in cycles t..t+BURST_LEN-1; `done` in cycle t+BURST_LEN. Each `valid`=0 cycle adds one cycle.
- Minimum spacing: next `go` accepted in the cycle after `done`.
- BURST_LEN=1:
  - Read: one issue, then DRAIN.
  - Write: the first `valid` goes straight to DONE.

## Test plan
- Write burst: reset, `go`/`w_rn`=1, `address`=13'h0100, `valid`=1 for 16 cycles with data 8'h00..8'h0F. Required: SRAM 0x100..0x10F = 00..0F; `done` one cycle after the last beat; `busy` high for exactly 16 cycles.
- Read back: `go`/`w_rn`=0, `address`=13'h0100, RD_LAT=1. Required: `rd_valid` high for 16 contiguous cycles starting 1 cycle after `go`, `rd_data`=00..0F; `done` 17 cycles after `go`.
- Stalled write: `valid` pattern 1,0,0,1,… for 16 beats. Required: only `valid` cycles write; addresses stay contiguous; `done` delayed by the stall count.
- Wrap: write burst at 13'h1FF8. Required: the last 8 words land at 0x0000..0x0007, `sram_addr` goes 1FFF→0000.
- Ignored `go` and latency: pulse `go` (write, `address`=0) mid-read. Required: no state change and the read completes normally. Repeat with RD_LAT=3: DRAIN lasts 3 cycles.
- Reset mid-burst: assert `rst` at beat 5 of a read. Required: next cycle IDLE with all outputs 0; no further `rd_valid`; a new `go` works normally.

Source files
------------

// File: rtl/dsec_mem_con_if.sv
// DSEC-side request/data signals and SRAM bus of the burst memory controller.
// slave: the controller; master: the DSEC/SRAM side.
interface dsec_mem_con_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] address;
  logic              w_rn;
  logic              go;
  logic              valid;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic              sram_ce;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  address, w_rn, go, valid, wr_data, sram_rdata,
    output rd_data, rd_valid, busy, done, sram_ce, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output address, w_rn, go, valid, wr_data, sram_rdata,
    input  rd_data, rd_valid, busy, done, sram_ce, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/dsec_mem_con.sv
// Fixed-length burst controller between the DSEC test controller and a
// synchronous SRAM: stalled write bursts, pipelined read bursts with rd_valid.
module dsec_mem_con #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 16,
  parameter int RD_LAT    = 1
) (
  input  logic           clk,
  input  logic           rst,
  dsec_mem_con_if.slave  bus
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [CNT_W-1:0]   r_cnt;
  logic [RD_LAT-1:0]  r_vld_pipe;

  logic w_load, w_wr, w_issue, w_busy, w_done, w_last, w_drain_empty;

  assign w_last = (r_cnt == LAST_CNT);
  // Once only the last stage may still hold a word, this is the final DRAIN cycle.
  assign w_drain_empty = ((r_vld_pipe << 1) == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_wr        = 1'b0;
    w_issue     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.go) begin
          w_load      = 1'b1;
          w_state_nxt = bus.w_rn ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        w_busy = 1'b1;
        w_wr   = bus.valid;
        if (bus.valid && w_last) w_state_nxt = S_DONE;
      end
      S_READ: begin
        w_busy  = 1'b1;
        w_issue = 1'b1;
        if (w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (w_drain_empty) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_vld_pipe <= (r_vld_pipe << 1) | RD_LAT'(w_issue);
      if (w_load) begin
        r_addr <= bus.address;
        r_cnt  <= '0;
      end else if (w_wr || w_issue) begin
        // Address wraps modulo 2**ADDR_W, so bursts may cross the top.
        r_addr <= r_addr + ADDR_W'(1);
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.sram_ce    = w_wr | w_issue;
  assign bus.sram_we    = w_wr;
  assign bus.sram_addr  = r_addr;
  assign bus.sram_wdata = (r_state == S_WRITE) ? bus.wr_data : '0;
  assign bus.rd_data    = bus.sram_rdata;
  assign bus.rd_valid   = r_vld_pipe[RD_LAT-1];
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;

endmodule

// File: tb/tb_dsec_mem_con.sv
// Bench for dsec_mem_con: three instances (16/lat1, 16/lat3, 1/lat2), each with an
// SRAM model, checked cycle by cycle against a burst-level reference.
module tb_dsec_mem_con;
  localparam int AW = 13;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] t_addr;
  logic          t_wrn, t_valid;
  logic [DW-1:0] t_wdata;
  logic [2:0]    t_go;

  int ncmp = 0;
  int nfail = 0;
  int bl[3] = '{16, 16, 1};
  int lt[3] = '{1, 3, 2};

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          rdv;
    logic          ce;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } obs_t;

  dsec_mem_con_if #(.ADDR_W(AW), .DATA_W(DW)) if0 (), if1 (), if2 ();

  dsec_mem_con #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(16), .RD_LAT(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  dsec_mem_con #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(16), .RD_LAT(3)) u1 (.clk(clk), .rst(rst), .bus(if1));
  dsec_mem_con #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(1),  .RD_LAT(2)) u2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.address = t_addr;  assign if1.address = t_addr;  assign if2.address = t_addr;
  assign if0.w_rn    = t_wrn;   assign if1.w_rn    = t_wrn;   assign if2.w_rn    = t_wrn;
  assign if0.valid   = t_valid; assign if1.valid   = t_valid; assign if2.valid   = t_valid;
  assign if0.wr_data = t_wdata; assign if1.wr_data = t_wdata; assign if2.wr_data = t_wdata;
  assign if0.go      = t_go[0]; assign if1.go      = t_go[1]; assign if2.go      = t_go[2];

  // SRAM models: one array per instance, read data delayed by that instance's latency
  logic [DW-1:0] sram [3][8192];
  logic [DW-1:0] rp0;
  logic [DW-1:0] rp1 [3];
  logic [DW-1:0] rp2 [2];
  always @(posedge clk) begin
    if (if0.sram_ce && if0.sram_we) sram[0][if0.sram_addr] <= if0.sram_wdata;
    if (if1.sram_ce && if1.sram_we) sram[1][if1.sram_addr] <= if1.sram_wdata;
    if (if2.sram_ce && if2.sram_we) sram[2][if2.sram_addr] <= if2.sram_wdata;
    rp0    <= sram[0][if0.sram_addr];
    rp1[0] <= sram[1][if1.sram_addr];
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
    rp2[0] <= sram[2][if2.sram_addr];
    rp2[1] <= rp2[0];
  end
  assign if0.sram_rdata = rp0;
  assign if1.sram_rdata = rp1[2];
  assign if2.sram_rdata = rp2[1];

  // Reference memory image: what each burst should have stored, and where
  logic [DW-1:0] refm [3][8192];
  bit            refv [3][8192];

  function automatic obs_t get(input int sel);
    obs_t o;
    case (sel)
      0:       o = {if0.busy, if0.done, if0.rd_valid, if0.sram_ce, if0.sram_we, if0.sram_addr, if0.sram_wdata, if0.rd_data};
      1:       o = {if1.busy, if1.done, if1.rd_valid, if1.sram_ce, if1.sram_we, if1.sram_addr, if1.sram_wdata, if1.rd_data};
      default: o = {if2.busy, if2.done, if2.rd_valid, if2.sram_ce, if2.sram_we, if2.sram_addr, if2.sram_wdata, if2.rd_data};
    endcase
    return o;
  endfunction

  // One burst: smode 0 = valid every cycle with data = beat index, 1 = valid on
  // every third cycle, 2 = random valid. ig = cycle to pulse an ignored go (-1 none);
  // gdone = also pulse go during the done cycle.
  task automatic burst(input int sel, input bit wr, input logic [AW-1:0] a,
                       input int smode, input int ig, input bit gdone);
    int L, lat, k, c, lim;
    bit fin, v;
    obs_t o, e, m;
    logic [DW-1:0] d;
    logic [AW-1:0] ea;
    L = bl[sel]; lat = lt[sel]; k = 0; c = 0; fin = 0; lim = L * 8 + lat + 10;
    t_addr = a; t_wrn = wr; t_valid = 1'b0; t_go[sel] = 1'b1;
    @(negedge clk);
    o = get(sel); ncmp++;
    if (o.busy !== 1'b0) begin
      nfail++; $display("FAIL pre_go_idle sel=%0d got busy=%b want 0", sel, o.busy);
    end
    @(posedge clk); #1;
    t_go[sel] = 1'b0; t_addr = AW'($urandom); t_wrn = 1'($urandom);
    while (!fin && c < lim) begin
      v = 1'b0;
      d = DW'($urandom);
      if (wr && k < L) begin
        if (smode == 0) begin v = 1'b1; d = DW'(k); end
        else if (smode == 1) v = (c % 3 == 0);
        else v = 1'($urandom_range(0, 1));
      end
      t_valid = v; t_wdata = d;
      if (c == ig) begin t_go[sel] = 1'b1; t_wrn = 1'b1; t_addr = '0; end
      e = '0; m = '0;
      m.busy = 1'b1; m.done = 1'b1; m.rdv = 1'b1; m.ce = 1'b1; m.we = 1'b1;
      if (wr) begin
        if (k < L) begin
          e.busy = 1'b1; e.ce = v; e.we = v;
          m.addr = '1;  e.addr = AW'(a + k);
          m.wdata = '1; e.wdata = d;
          if (v) begin
            refm[sel][AW'(a + k)] = d;
            refv[sel][AW'(a + k)] = 1'b1;
            k++;
          end
        end else begin
          e.done = 1'b1; fin = 1'b1;
        end
      end else begin
        if (c < L + lat) e.busy = 1'b1;
        else begin e.done = 1'b1; fin = 1'b1; end
        if (c < L) begin e.ce = 1'b1; m.addr = '1; e.addr = AW'(a + c); end
        if (c >= lat && c < lat + L) begin
          e.rdv = 1'b1;
          ea = AW'(a + (c - lat));
          if (refv[sel][ea]) begin m.rdata = '1; e.rdata = refm[sel][ea]; end
        end
      end
      if (fin && gdone) begin t_go[sel] = 1'b1; t_wrn = 1'($urandom); t_addr = AW'($urandom); end
      @(negedge clk);
      o = get(sel); ncmp++;
      if ((o & m) !== (e & m)) begin
        nfail++;
        $display("FAIL burst_cycle sel=%0d wr=%0d cyc=%0d got=%h want=%h", sel, wr, c, o & m, e & m);
      end
      @(posedge clk); #1;
      t_go[sel] = 1'b0;
      c++;
    end
    t_valid = 1'b0;
    if (!fin) begin
      ncmp++; nfail++;
      $display("FAIL burst_timeout sel=%0d got no done in %0d cycles want done", sel, lim);
    end
    if (gdone) begin
      @(negedge clk);
      o = get(sel); ncmp++;
      if (o.busy !== 1'b0 || o.ce !== 1'b0) begin
        nfail++; $display("FAIL go_in_done sel=%0d got busy=%b ce=%b want 0 0", sel, o.busy, o.ce);
      end
      @(posedge clk); #1;
    end
    if (wr) begin
      for (int i = 0; i < L; i++) begin
        ea = AW'(a + i);
        ncmp++;
        if (sram[sel][ea] !== refm[sel][ea]) begin
          nfail++; $display("FAIL sram_word sel=%0d addr=%h got=%h want=%h", sel, ea, sram[sel][ea], refm[sel][ea]);
        end
      end
    end
  endtask

  task automatic test_reset;
    obs_t o;
    rst = 1'b1; t_go = '0; t_addr = '0; t_wrn = 1'b0; t_valid = 1'b0; t_wdata = '0;
    @(posedge clk); #1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      o = get(s); o.rdata = '0; ncmp++;
      if (o !== '0) begin nfail++; $display("FAIL reset_outputs sel=%0d got=%h want=0", s, o); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write;
    burst(0, 1'b1, 13'h0100, 0, -1, 1'b0);
  endtask

  task automatic test_readback;
    burst(0, 1'b0, 13'h0100, 0, -1, 1'b0);
  endtask

  task automatic test_stall_write;
    burst(0, 1'b1, 13'h0200, 1, -1, 1'b0);
    burst(0, 1'b1, 13'h0300, 2, -1, 1'b1);
    burst(0, 1'b0, 13'h0200, 0, -1, 1'b0);
  endtask

  task automatic test_wrap;
    burst(0, 1'b1, 13'h1FF8, 2, -1, 1'b0);
    burst(0, 1'b0, 13'h1FF8, 0, -1, 1'b0);
  endtask

  task automatic test_ignored_go;
    burst(0, 1'b0, 13'h0300, 0, 6, 1'b0);
    burst(1, 1'b1, 13'h0040, 2, 5, 1'b0);
    burst(1, 1'b0, 13'h0040, 0, 7, 1'b1);
    burst(1, 1'b0, 13'h0040, 0, 17, 1'b0);
  endtask

  task automatic test_burst_len1;
    burst(2, 1'b1, 13'h0055, 1, -1, 1'b0);
    burst(2, 1'b0, 13'h0055, 0, -1, 1'b1);
    burst(2, 1'b1, 13'h1FFF, 0, -1, 1'b0);
    burst(2, 1'b0, 13'h1FFF, 0, 1, 1'b0);
  endtask

  task automatic test_reset_mid_read;
    obs_t o;
    t_addr = 13'h0100; t_wrn = 1'b0; t_go[0] = 1'b1;
    @(posedge clk); #1;
    t_go[0] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    o = get(0); o.rdata = '0; ncmp++;
    if (o !== '0) begin nfail++; $display("FAIL reset_mid_read sel=0 got=%h want=0", o); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      ncmp++;
      if (if0.rd_valid !== 1'b0 || if0.busy !== 1'b0) begin
        nfail++; $display("FAIL reset_drop sel=0 cyc=%0d got rdv=%b busy=%b want 0 0", i, if0.rd_valid, if0.busy);
      end
    end
    @(posedge clk); #1;
    burst(0, 1'b0, 13'h0100, 0, -1, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      int s;
      logic [AW-1:0] a;
      s = $urandom_range(0, 2);
      a = (i % 2 == 0) ? AW'($urandom) : 13'h1FF0;
      burst(s, 1'b1, a, 2, -1, 1'b0);
      burst(s, 1'b0, a, 0, -1, 1'($urandom));
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_readback;
    test_stall_write;
    test_wrap;
    test_ignored_go;
    test_burst_len1;
    test_reset_mid_read;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
